// File: rtl/scan_decoder_if.sv
// Control-side bundle for scan_decoder: enable/mode/select/dwell in, strobes/index/wrap out.
// Names follow the peripheral pin list so board-level netlists read one-to-one.
interface scan_decoder_if #(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) ();
    logic                 G_L;
    logic                 MODE;
    logic [N-1:0]         SEL;
    logic [DWELL_W-1:0]   DWELL;
    logic [(1<<N)-1:0]    Y_L;
    logic [N-1:0]         IDX;
    logic                 WRAP;

    modport master (
        output G_L, MODE, SEL, DWELL,
        input  Y_L, IDX, WRAP
    );

    modport slave (
        input  G_L, MODE, SEL, DWELL,
        output Y_L, IDX, WRAP
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N active-low decoder with autonomous scan (dwell + optional blanking gap).
// Latency: 1 cycle from sampled inputs to Y_L/IDX/WRAP; no combinational input-to-output path.
// Backpressure: none; G_L high pauses the scan and blanks all strobes.
module scan_decoder #(
    parameter int N       = 2,
    parameter int DWELL_W = 8,
    parameter int BLANK   = 0
) (
    input logic           CLK,
    input logic           RESET,
    scan_decoder_if.slave bus
);
    localparam int M  = 1 << N;
    localparam int GW = ($clog2(BLANK + 1) > 1) ? $clog2(BLANK + 1) : 1;
    localparam logic [GW-1:0]      GAP_LAST = GW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [GW-1:0]      GAP_ONE  = GW'(1);
    localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);
    localparam logic [N-1:0]       IDX_ONE  = N'(1);

    typedef enum logic {HOLD, GAP} state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [N-1:0]       idx_q, idx_d, idx_nxt;
    logic [M-1:0]       y_q, y_d;
    logic               wrap_q, wrap_d;

    function automatic logic [M-1:0] one_cold(input logic [N-1:0] i);
        return ~(M'(1) << i);
    endfunction

    assign idx_nxt = idx_q + IDX_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        y_d     = '1;
        wrap_d  = 1'b0;
        if (!bus.MODE) begin
            // Direct decode also abandons any scan progress so a later scan starts clean.
            state_d = HOLD;
            cnt_d   = '0;
            gap_d   = '0;
            if (!bus.G_L) begin
                idx_d = bus.SEL;
                y_d   = one_cold(bus.SEL);
            end
        end else if (!bus.G_L) begin
            case (state_q)
                HOLD: begin
                    if (cnt_q >= bus.DWELL) begin
                        cnt_d = '0;
                        if (BLANK == 0) begin
                            idx_d  = idx_nxt;
                            y_d    = one_cold(idx_nxt);
                            wrap_d = &idx_q;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        y_d   = one_cold(idx_q);
                    end
                end
                GAP: begin
                    if (gap_q >= GAP_LAST) begin
                        gap_d   = '0;
                        state_d = HOLD;
                        idx_d   = idx_nxt;
                        y_d     = one_cold(idx_nxt);
                        wrap_d  = &idx_q;
                    end else begin
                        gap_d = gap_q + GAP_ONE;
                    end
                end
                default: state_d = HOLD;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            y_q     <= '1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.Y_L  = y_q;
    assign bus.IDX  = idx_q;
    assign bus.WRAP = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: u_dut0 has no blanking gap, u_dut1 has a one-cycle gap.
module tb_scan_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       g_l  = 1'b1;
    logic       mode = 1'b0;
    logic [1:0] sel  = 2'd0;
    logic [7:0] dwell = 8'd0;

    int total  = 0;
    int passed = 0;

    scan_decoder_if #(.N(2), .DWELL_W(8)) if0 ();
    scan_decoder_if #(.N(2), .DWELL_W(8)) if1 ();

    assign if0.G_L = g_l;  assign if0.MODE = mode;  assign if0.SEL = sel;  assign if0.DWELL = dwell;
    assign if1.G_L = g_l;  assign if1.MODE = mode;  assign if1.SEL = sel;  assign if1.DWELL = dwell;

    scan_decoder #(.N(2), .DWELL_W(8), .BLANK(0)) u_dut0 (.CLK(clk), .RESET(rst), .bus(if0));
    scan_decoder #(.N(2), .DWELL_W(8), .BLANK(1)) u_dut1 (.CLK(clk), .RESET(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oc(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] dir_y [4];
        logic [3:0] blank_y [8];
        logic [1:0] blank_idx [8];
        logic [3:0] prev;
        int e;

        dir_y     = '{4'hE, 4'hD, 4'hB, 4'h7};
        blank_y   = '{4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF, 4'hE};
        blank_idx = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

        // Reset values, no clock edge needed
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_y0", if0.Y_L, 4'hF);
        chk("rst_idx0", if0.IDX, 0);
        chk("rst_wrap0", if0.WRAP, 0);
        chk("rst_y1", if1.Y_L, 4'hF);
        step();
        step();
        rst = 1'b0;

        // Direct sweep, each result one cycle late
        g_l  = 1'b0;
        mode = 1'b0;
        prev = 4'hF;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("dir_late", if0.Y_L, prev);
            step();
            chk("dir_y", if0.Y_L, dir_y[s]);
            chk("dir_idx", if0.IDX, s);
            prev = dir_y[s];
        end
        g_l = 1'b1;
        step();
        chk("dir_off_y", if0.Y_L, 4'hF);
        chk("dir_off_idx", if0.IDX, 3);

        // Scan, DWELL=2, no gap: 3 cycles per index, wrap every 12
        g_l = 1'b0;
        sel = 2'd0;
        step();
        chk("scan_start_y", if0.Y_L, 4'hE);
        mode  = 1'b1;
        dwell = 8'd2;
        for (int k = 1; k <= 24; k++) begin
            step();
            e = (k / 3) % 4;
            chk("scan_idx", if0.IDX, e);
            chk("scan_y", if0.Y_L, oc(e));
            chk("scan_wrap", if0.WRAP, (k % 12 == 0) ? 1 : 0);
        end

        // DWELL=0: u_dut1 inserts a 1-cycle gap, u_dut0 advances every cycle
        mode  = 1'b0;
        sel   = 2'd0;
        dwell = 8'd0;
        step();
        mode = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("blank_y", if1.Y_L, blank_y[k-1]);
            chk("blank_idx", if1.IDX, blank_idx[k-1]);
            chk("blank_wrap", if1.WRAP, (k == 8) ? 1 : 0);
            chk("fast_idx", if0.IDX, k % 4);
            chk("fast_wrap", if0.WRAP, (k % 4 == 0) ? 1 : 0);
        end

        // Pause at count 2 with DWELL=3, then resume
        mode = 1'b0;
        sel  = 2'd1;
        step();
        mode  = 1'b1;
        dwell = 8'd3;
        step();
        step();
        chk("pre_pause_y", if0.Y_L, 4'hD);
        g_l = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("pause_y", if0.Y_L, 4'hF);
            chk("pause_idx", if0.IDX, 1);
            chk("pause_wrap", if0.WRAP, 0);
        end
        g_l = 1'b0;
        step();
        chk("resume_hold_y", if0.Y_L, 4'hD);
        step();
        chk("resume_adv_y", if0.Y_L, 4'hB);
        chk("resume_adv_idx", if0.IDX, 2);

        // DWELL lowered below current count forces an advance
        mode = 1'b0;
        sel  = 2'd0;
        step();
        mode  = 1'b1;
        dwell = 8'd9;
        repeat (6) step();
        chk("drop_pre_y", if0.Y_L, 4'hE);
        dwell = 8'd1;
        step();
        chk("drop_y", if0.Y_L, 4'hD);
        chk("drop_idx", if0.IDX, 1);

        // Mode switch while u_dut1 is in its gap
        mode  = 1'b0;
        sel   = 2'd0;
        dwell = 8'd0;
        step();
        mode = 1'b1;
        step();
        chk("gap_y", if1.Y_L, 4'hF);
        chk("gap_idx", if1.IDX, 0);
        mode = 1'b0;
        sel  = 2'd2;
        step();
        chk("gap_abort_y", if1.Y_L, 4'hB);
        chk("gap_abort_idx", if1.IDX, 2);

        // Asynchronous reset mid-scan, then release into direct SEL=2
        mode  = 1'b1;
        dwell = 8'd2;
        step();
        step();
        chk("mid_scan_y", if0.Y_L, 4'hB);
        #2 rst = 1'b1;
        #1;
        chk("arst_y0", if0.Y_L, 4'hF);
        chk("arst_idx0", if0.IDX, 0);
        chk("arst_wrap0", if0.WRAP, 0);
        chk("arst_y1", if1.Y_L, 4'hF);
        mode = 1'b0;
        g_l  = 1'b0;
        sel  = 2'd2;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rel_before_edge_y", if0.Y_L, 4'hF);
        step();
        chk("rel_y", if0.Y_L, 4'hB);
        chk("rel_idx", if0.IDX, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
